axis_event_fifo: RTL and testbench

//  Synchronous AXI-Stream FIFO that buffers 32-bit event words, e.g. packed mouse

---
 rtl/axis_event_fifo.sv | 91 +++++++++
 tb/tb_axis_event_fifo.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_event_fifo.sv
// axis_event_fifo: synchronous first-word-fall-through AXI-Stream FIFO for event words.
// It can either back-pressure the producer or drop words when full. Dropped words
// are counted in a saturating counter that can be cleared.
module axis_event_fifo #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned CNT_W        = 16,
  parameter bit          DROP_ON_FULL = 1'b1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [DATA_W-1:0]       s_tdata,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  output logic [DATA_W-1:0]       m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [$clog2(DEPTH):0]  level,
  output logic [CNT_W-1:0]        drop_count,
  input  logic                    drop_clear
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic              drop;

  // Status flags, handshakes and head-of-FIFO output.
  always_comb begin
    empty    = (wr_ptr == rd_ptr);
    full     = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
               (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    s_tready = DROP_ON_FULL ? 1'b1 : !full;
    m_tvalid = !empty;
    m_tdata  = mem[rd_ptr[ADDR_W-1:0]];
    pop      = m_tvalid & m_tready;
    push     = s_tvalid & s_tready & (!full | pop);
    drop     = DROP_ON_FULL & s_tvalid & full & !pop;
  end

  // Storage write. When the FIFO is full and a push coincides with a pop,
  // the write lands in the slot being vacated by the pop.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[ADDR_W-1:0]] <= s_tdata;
    end
  end

  // Pointers wrap modulo 2*DEPTH by natural overflow of the extra bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Registered fill level; it is unchanged when push and pop coincide.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      level <= '0;
    end else begin
      case ({push, pop})
        2'b10:   level <= level + PTR_W'(1);
        2'b01:   level <= level - PTR_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Saturating drop counter. A drop in the same cycle as a clear still counts.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      drop_count <= '0;
    end else if (drop_clear) begin
      drop_count <= drop ? CNT_W'(1) : '0;
    end else if (drop && (drop_count != '1)) begin
      drop_count <= drop_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_axis_event_fifo.sv
// tb_axis_event_fifo: self-checking bench for axis_event_fifo.
// Instance A is the default drop-on-full FIFO, B is a back-pressuring FIFO, and
// C is a small drop-on-full FIFO with a narrow counter.
module tb_axis_event_fifo;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // Instance A: DEPTH 16, CNT_W 16, DROP_ON_FULL 1
  logic [31:0] a_sd, a_md;
  logic        a_sv, a_sr, a_mv, a_mr, a_clr;
  logic [4:0]  a_lvl;
  logic [15:0] a_dc;

  // Shared stimulus for instances B and C
  logic [31:0] bc_sd, b_md, c_md;
  logic        bc_sv, bc_mr, bc_clr, b_sr, b_mv, c_sr, c_mv;
  logic [4:0]  b_lvl;
  logic [15:0] b_dc;
  logic [2:0]  c_lvl;
  logic [2:0]  c_dc;

  axis_event_fifo #(.DATA_W(32), .DEPTH(16), .CNT_W(16), .DROP_ON_FULL(1'b1)) dut_a (
    .clk(clk), .resetn(resetn), .s_tdata(a_sd), .s_tvalid(a_sv), .s_tready(a_sr),
    .m_tdata(a_md), .m_tvalid(a_mv), .m_tready(a_mr), .level(a_lvl),
    .drop_count(a_dc), .drop_clear(a_clr));

  axis_event_fifo #(.DATA_W(32), .DEPTH(16), .CNT_W(16), .DROP_ON_FULL(1'b0)) dut_b (
    .clk(clk), .resetn(resetn), .s_tdata(bc_sd), .s_tvalid(bc_sv), .s_tready(b_sr),
    .m_tdata(b_md), .m_tvalid(b_mv), .m_tready(bc_mr), .level(b_lvl),
    .drop_count(b_dc), .drop_clear(bc_clr));

  axis_event_fifo #(.DATA_W(32), .DEPTH(4), .CNT_W(3), .DROP_ON_FULL(1'b1)) dut_c (
    .clk(clk), .resetn(resetn), .s_tdata(bc_sd), .s_tvalid(bc_sv), .s_tready(c_sr),
    .m_tdata(c_md), .m_tvalid(c_mv), .m_tready(bc_mr), .level(c_lvl),
    .drop_count(c_dc), .drop_clear(bc_clr));

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model for instance A: a queue of stored words plus a drop tally.
  logic [31:0] mq[$];
  int unsigned mdc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of instance A, checked against the queue model after the edge.
  task automatic step_a(input logic tv, input logic [31:0] td, input logic tr, input logic clr);
    bit m_has, m_pop, m_full, m_push, m_drop;
    a_sv = tv; a_sd = td; a_mr = tr; a_clr = clr;
    m_has  = (mq.size() != 0);
    m_pop  = m_has && tr;
    m_full = (mq.size() == 16);
    m_push = tv && (!m_full || m_pop);
    m_drop = tv && m_full && !m_pop;
    @(posedge clk); #1;
    if (m_pop)  void'(mq.pop_front());
    if (m_push) mq.push_back(td);
    if (clr)                        mdc = m_drop ? 1 : 0;
    else if (m_drop && mdc < 65535) mdc = mdc + 1;
    chk("a_level", 32'(a_lvl), 32'(mq.size()));
    chk("a_m_tvalid", 32'(a_mv), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("a_m_tdata", a_md, mq[0]);
    chk("a_drop_count", 32'(a_dc), mdc);
    chk("a_s_tready", 32'(a_sr), 32'd1);
  endtask

  task automatic step_bc(input logic tv, input logic [31:0] td, input logic tr, input logic clr);
    bc_sv = tv; bc_sd = td; bc_mr = tr; bc_clr = clr;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        tv;
    logic [31:0] td;
    logic        tr;
    logic        clr;
    logic        ev;
    logic [31:0] ed;
    logic [4:0]  el;
    logic [15:0] edc;
  } vec_t;

  vec_t vt[9];

  initial begin
    // Expected values after the edge, starting from reset.
    vt[0] = '{1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b1, 32'hA5A5_0001, 5'd1, 16'd0};
    vt[1] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'hA5A5_0001, 5'd1, 16'd0};
    vt[2] = '{1'b1, 32'h0000_0002, 1'b0, 1'b0, 1'b1, 32'hA5A5_0001, 5'd2, 16'd0};
    vt[3] = '{1'b1, 32'h0000_0003, 1'b1, 1'b0, 1'b1, 32'h0000_0002, 5'd2, 16'd0};
    vt[4] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0000_0003, 5'd1, 16'd0};
    vt[5] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         5'd0, 16'd0};
    vt[6] = '{1'b1, 32'h0000_0007, 1'b1, 1'b0, 1'b1, 32'h0000_0007, 5'd1, 16'd0};
    vt[7] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         5'd0, 16'd0};
    vt[8] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         5'd0, 16'd0};

    a_sv = 0; a_sd = '0; a_mr = 0; a_clr = 0;
    bc_sv = 0; bc_sd = '0; bc_mr = 0; bc_clr = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_a_level", 32'(a_lvl), 32'd0);
    chk("reset_a_m_tvalid", 32'(a_mv), 32'd0);
    chk("reset_a_drop_count", 32'(a_dc), 32'd0);
    chk("reset_a_s_tready", 32'(a_sr), 32'd1);
    chk("reset_b_s_tready", 32'(b_sr), 32'd1);
    resetn = 1'b1;

    // Table-driven vectors on instance A
    for (int i = 0; i < 9; i++) begin
      step_a(vt[i].tv, vt[i].td, vt[i].tr, vt[i].clr);
      chk($sformatf("vec%0d_m_tvalid", i), 32'(a_mv), 32'(vt[i].ev));
      if (vt[i].ev) chk($sformatf("vec%0d_m_tdata", i), a_md, vt[i].ed);
      chk($sformatf("vec%0d_level", i), 32'(a_lvl), 32'(vt[i].el));
      chk($sformatf("vec%0d_drop", i), 32'(a_dc), 32'(vt[i].edc));
    end

    // Fill with 0..15, no pop
    for (int i = 0; i < 16; i++) step_a(1'b1, 32'(i), 1'b0, 1'b0);
    chk("fill_level", 32'(a_lvl), 32'd16);
    chk("fill_head", a_md, 32'd0);
    // Three offers while full are dropped
    for (int i = 0; i < 3; i++) step_a(1'b1, 32'(100 + i), 1'b0, 1'b0);
    chk("drop3_count", 32'(a_dc), 32'd3);
    chk("drop3_level", 32'(a_lvl), 32'd16);
    chk("drop3_head", a_md, 32'd0);
    // Push and pop while full
    step_a(1'b1, 32'h99, 1'b1, 1'b0);
    chk("fullpp_level", 32'(a_lvl), 32'd16);
    chk("fullpp_drop", 32'(a_dc), 32'd3);
    chk("fullpp_head", a_md, 32'd1);
    // Clear coincident with a drop, then clear alone
    step_a(1'b1, 32'h55, 1'b0, 1'b1);
    chk("clr_with_drop", 32'(a_dc), 32'd1);
    step_a(1'b0, 32'h0, 1'b0, 1'b1);
    chk("clr_alone", 32'(a_dc), 32'd0);
    // Drain: order 1..15 then 0x99
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d", i), a_md, (i < 15) ? 32'(i + 1) : 32'h99);
      step_a(1'b0, 32'h0, 1'b1, 1'b0);
    end
    chk("drain_level", 32'(a_lvl), 32'd0);
    a_mr = 0;

    // Instances B (back-pressure) and C (DEPTH 4, 3-bit counter)
    for (int i = 0; i < 16; i++) step_bc(1'b1, 32'(i), 1'b0, 1'b0);
    chk("b_full_level", 32'(b_lvl), 32'd16);
    chk("b_full_s_tready", 32'(b_sr), 32'd0);
    chk("c_full_level", 32'(c_lvl), 32'd4);
    chk("c_sat_drop", 32'(c_dc), 32'd7);
    chk("c_s_tready", 32'(c_sr), 32'd1);
    step_bc(1'b1, 32'd16, 1'b1, 1'b0);
    chk("b_fullpp_level", 32'(b_lvl), 32'd15);
    chk("b_fullpp_head", b_md, 32'd1);
    chk("c_fullpp_level", 32'(c_lvl), 32'd4);
    chk("c_fullpp_drop", 32'(c_dc), 32'd7);
    step_bc(1'b1, 32'd17, 1'b0, 1'b1);
    chk("b_refill_level", 32'(b_lvl), 32'd16);
    chk("b_refill_s_tready", 32'(b_sr), 32'd0);
    chk("b_drop_count", 32'(b_dc), 32'd0);
    chk("c_clr_with_drop", 32'(c_dc), 32'd1);
    step_bc(1'b0, 32'd0, 1'b0, 1'b1);
    chk("c_clr_alone", 32'(c_dc), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b_drain%0d", i), b_md, 32'(i + 1));
      chk($sformatf("c_drain%0d", i), c_md, (i < 3) ? 32'(i + 1) : 32'd16);
      step_bc(1'b0, 32'd0, 1'b1, 1'b0);
    end
    chk("b_drain_level", 32'(b_lvl), 32'd12);
    chk("c_drain_m_tvalid", 32'(c_mv), 32'd0);

    // Asynchronous reset in the middle of a burst
    bc_sv = 1; bc_sd = 32'h1234; bc_mr = 0;
    a_sv = 1; a_sd = 32'h4321;
    #1 resetn = 1'b0;
    #1;
    chk("arst_b_level", 32'(b_lvl), 32'd0);
    chk("arst_b_m_tvalid", 32'(b_mv), 32'd0);
    chk("arst_c_level", 32'(c_lvl), 32'd0);
    chk("arst_a_level", 32'(a_lvl), 32'd0);
    chk("arst_a_m_tvalid", 32'(a_mv), 32'd0);
    a_sv = 0;
    @(posedge clk); #1;
    resetn = 1'b1;
    mq.delete(); mdc = 0;
    chk("rel_b_m_tvalid", 32'(b_mv), 32'd0);
    step_bc(1'b1, 32'hBEEF, 1'b0, 1'b0);
    chk("rel_b_first_valid", 32'(b_mv), 32'd1);
    chk("rel_b_first_data", b_md, 32'hBEEF);
    chk("rel_b_level", 32'(b_lvl), 32'd1);
    bc_sv = 0;

    // Randomized traffic on A against the queue model, with one mid-run reset
    for (int i = 0; i < 3000; i++) begin
      logic tv, tr, clr;
      if (i == 1500) begin
        #1 resetn = 1'b0;
        #1;
        chk("rand_arst_level", 32'(a_lvl), 32'd0);
        chk("rand_arst_m_tvalid", 32'(a_mv), 32'd0);
        chk("rand_arst_drop", 32'(a_dc), 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        mq.delete(); mdc = 0;
      end
      tv  = ($urandom_range(0, 99) < 80);
      tr  = ($urandom_range(0, 99) < (((i / 250) % 2) ? 85 : 25));
      clr = ($urandom_range(0, 99) < 4);
      step_a(tv, $urandom, tr, clr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
